// File: rtl/abs_sum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : abs_sum_pkg
// Description : Shared definitions for the abs_sum_window streaming stage.
//               - default sample / accumulator / window-length widths
//               - accumulate/hold state encoding
//               - magnitude and accumulator typedefs at default widths
// Revision    : 1.0 - initial release
// ============================================================================
package abs_sum_pkg;

    localparam int C_WIDTH     = 32;
    localparam int C_ACC_WIDTH = 40;
    localparam int C_LEN_WIDTH = 8;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    typedef logic [C_WIDTH-1:0]     mag_t;
    typedef logic [C_ACC_WIDTH-1:0] acc_t;

endpackage
`default_nettype wire

// File: rtl/abs_mag.sv
`default_nettype none
// ============================================================================
// Module      : abs_mag
// Description : Combinational two's-complement to magnitude conversion.
//               The most negative input maps to 2^(WIDTH-1), which is
//               representable as an unsigned WIDTH-bit value.
// Ports       : data  in   WIDTH  signed sample
//               mag   out  WIDTH  unsigned magnitude
// Revision    : 1.0 - initial release
// ============================================================================
module abs_mag
    import abs_sum_pkg::*;
#(
    parameter int WIDTH = C_WIDTH
) (
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] mag
);

    assign mag = data[WIDTH-1] ? (~data + {{(WIDTH-1){1'b0}}, 1'b1}) : data;

endmodule
`default_nettype wire

// File: rtl/abs_sum_window.sv
`default_nettype none
// ============================================================================
// Module      : abs_sum_window
// Description : Two-stage valid/ready pipeline that accumulates |sample| over
//               a programmable window and emits one L1-norm per window.
//               Stage 1 registers the magnitude and a last-of-window flag;
//               stage 2 accumulates and holds the result until accepted.
// Config      : ABS_SUM_SAT_EN - when defined, the accumulator saturates at
//               2^ACC_WIDTH-1 on overflow; otherwise it wraps. out_ovf flags
//               the overflow in both builds.
// Ports       : clk        in   1          clock, rising edge
//               rst_n      in   1          async active-low reset
//               win_len    in   LEN_WIDTH  samples per window (0 -> 1)
//               in_valid   in   1          sample valid
//               in_ready   out  1          stage can accept a sample
//               in_data    in   WIDTH      signed sample
//               out_valid  out  1          result valid
//               out_ready  in   1          downstream accepts result
//               out_sum    out  ACC_WIDTH  sum of magnitudes
//               out_ovf    out  1          accumulation overflowed
// Revision    : 1.0 - initial release
// ============================================================================
module abs_sum_window
    import abs_sum_pkg::*;
#(
    parameter int WIDTH     = C_WIDTH,
    parameter int ACC_WIDTH = C_ACC_WIDTH,
    parameter int LEN_WIDTH = C_LEN_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [LEN_WIDTH-1:0] win_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic                 out_ovf
);

    // Stage 1 state
    logic                 s1_valid;
    logic                 s1_last;
    logic [WIDTH-1:0]     s1_mag;
    logic [LEN_WIDTH-1:0] cnt;
    logic [LEN_WIDTH-1:0] len_q;

    // Stage 2 state
    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic                 ovf;

    // Combinational helpers
    logic                 accept;
    logic [WIDTH-1:0]     mag_w;
    logic [LEN_WIDTH-1:0] len_sel;
    logic [LEN_WIDTH-1:0] eff_len;
    logic                 last_w;
    logic [ACC_WIDTH:0]   sum_w;
    logic [ACC_WIDTH-1:0] acc_nxt;
    logic                 ovf_nxt;

    abs_mag #(
        .WIDTH (WIDTH)
    ) u_abs_mag (
        .data (in_data),
        .mag  (mag_w)
    );

    // Stage 1 is never occupied while a result is held, so the only stalls
    // are the last-of-window bubble and a pending, unaccepted result. The
    // rst_n term keeps in_ready low for the whole reset interval.
    assign in_ready = rst_n
                    && !(s1_valid && s1_last)
                    && !(state == HOLD && !out_ready);
    assign accept   = in_valid && in_ready;

    // The first sample of a window uses the live win_len; later samples use
    // the copy latched alongside that first sample.
    assign len_sel  = (cnt == '0) ? win_len : len_q;
    assign eff_len  = (len_sel == '0) ? LEN_WIDTH'(1) : len_sel;
    assign last_w   = ((LEN_WIDTH+1)'(cnt) + (LEN_WIDTH+1)'(1))
                      == (LEN_WIDTH+1)'(eff_len);

    // One spare bit captures the carry-out of the accumulation.
    assign sum_w    = {1'b0, acc} + (ACC_WIDTH+1)'(s1_mag);
    assign ovf_nxt  = ovf | sum_w[ACC_WIDTH];
`ifdef ABS_SUM_SAT_EN
    assign acc_nxt  = ovf_nxt ? {ACC_WIDTH{1'b1}} : sum_w[ACC_WIDTH-1:0];
`else
    assign acc_nxt  = sum_w[ACC_WIDTH-1:0];
`endif

    // Stage 1: magnitude register and window counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_mag   <= '0;
            cnt      <= '0;
            len_q    <= '0;
        end else begin
            s1_valid <= accept;
            s1_last  <= accept && last_w;
            if (accept) begin
                s1_mag <= mag_w;
                if (cnt == '0) begin
                    len_q <= win_len;
                end
                cnt <= last_w ? '0 : cnt + LEN_WIDTH'(1);
            end
        end
    end

    // Stage 2: accumulate / hold FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (s1_valid) begin
                        acc <= acc_nxt;
                        ovf <= ovf_nxt;
                        if (s1_last) begin
                            state     <= HOLD;
                            out_sum   <= acc_nxt;
                            out_ovf   <= ovf_nxt;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= ACCUM;
                        acc       <= '0;
                        ovf       <= 1'b0;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_abs_sum_window.sv
`default_nettype none
// ============================================================================
// Module      : tb_abs_sum_window
// Description : Directed self-checking bench for abs_sum_window. A second
//               instance with a 33-bit accumulator exercises overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_abs_sum_window;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [7:0]  win_len;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] out_sum;
    logic        out_ovf;

    logic [7:0]  win_len_b;
    logic        in_valid_b;
    logic        in_ready_b;
    logic [31:0] in_data_b;
    logic        out_valid_b;
    logic        out_ready_b;
    logic [32:0] out_sum_b;
    logic        out_ovf_b;

    int n_checks = 0;
    int n_errors = 0;

    abs_sum_window u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .win_len   (win_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    abs_sum_window #(
        .ACC_WIDTH (33)
    ) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .win_len   (win_len_b),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .in_data   (in_data_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .out_sum   (out_sum_b),
        .out_ovf   (out_ovf_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called and returns 1ns after a rising edge.
    task automatic send(input logic [31:0] d);
        bit ok;
        int guard;
        ok       = 1'b0;
        guard    = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!ok && guard < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        check("send_accepted", 64'(ok), 64'd1);
    endtask

    task automatic wait_result(input string tag, input logic [39:0] exp_sum,
                               input logic exp_ovf, input int exp_lat);
        int n;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
        end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        if (exp_lat > 0) check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        check({tag, "_sum"}, 64'(out_sum), 64'(exp_sum));
        check({tag, "_ovf"}, 64'(out_ovf), 64'(exp_ovf));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] exp_b;
        int          n;
        rst_n       = 1'b0;
        win_len     = 8'd4;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b1;
        win_len_b   = 8'd4;
        in_valid_b  = 1'b0;
        in_data_b   = '0;
        out_ready_b = 1'b1;

        // Reset values
        #1;
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum",   64'(out_sum),   64'd0);
        check("rst_out_ovf",   64'(out_ovf),   64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Back-to-back window of 4, including the most negative value
        win_len = 8'd4;
        send(32'd5);
        send(32'hFFFF_FFFD);
        send(32'h8000_0000);
        send(32'hFFFF_FFFF);
        wait_result("w4", 40'h00_8000_0009, 1'b0, 2);

        // Zero length behaves as a window of one
        win_len = 8'd0;
        send(32'hFFFF_FFF9);
        check("len0_bubble_in_ready", 64'(in_ready), 64'd0);
        wait_result("len0_a", 40'd7, 1'b0, 2);
        send(32'd2);
        wait_result("len0_b", 40'd2, 1'b0, 2);

        // Back-pressure while a result is held
        win_len   = 8'd3;
        out_ready = 1'b0;
        send(32'd10);
        send(32'hFFFF_FFEC);
        send(32'd30);
        wait_result("bp_first", 40'd60, 1'b0, 2);
        in_data  = 32'd4;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid",    64'(out_valid), 64'd1);
            check("bp_hold_sum",      64'(out_sum),   64'd60);
            check("bp_hold_in_ready", 64'(in_ready),  64'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_result_dropped", 64'(out_valid), 64'd0);
        send(32'd5);
        send(32'd6);
        wait_result("bp_second", 40'd15, 1'b0, 2);

        // win_len change mid-window takes effect on the next window
        win_len = 8'd4;
        send(32'd1);
        win_len = 8'd2;
        send(32'd2);
        send(32'd3);
        send(32'd4);
        wait_result("len_chg_a", 40'd10, 1'b0, 2);
        send(32'd5);
        send(32'd6);
        wait_result("len_chg_b", 40'd11, 1'b0, 2);

        // 33-bit accumulator overflow
`ifdef ABS_SUM_SAT_EN
        exp_b = 33'h1_FFFF_FFFF;
`else
        exp_b = 33'h0_0000_0000;
`endif
        in_data_b  = 32'h8000_0000;
        in_valid_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ovf_in_ready", 64'(in_ready_b), 64'd1);
            @(posedge clk);
            #1;
        end
        in_valid_b = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (out_valid_b) break;
        end
        check("ovf_valid", 64'(out_valid_b), 64'd1);
        check("ovf_sum",   64'(out_sum_b),   64'(exp_b));
        check("ovf_flag",  64'(out_ovf_b),   64'd1);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-window discards the partial sum
        win_len = 8'd4;
        send(32'd1);
        send(32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_sum",   64'(out_sum),   64'd0);
        check("midrst_in_ready",  64'(in_ready),  64'd0);
        check("midrst_ovf_b",     64'(out_ovf_b), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_post_ready", 64'(in_ready), 64'd1);
        send(32'd1);
        send(32'd1);
        send(32'd1);
        send(32'd1);
        wait_result("after_rst", 40'd4, 1'b0, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/abs_sum_window.md
# abs_sum_window

Streaming stage that consumes 32-bit two's-complement samples, takes their absolute value, and accumulates the magnitudes over a programmable window. It emits one L1-norm sum per window and sits directly downstream of the combinational absolute-value/conditional-negate datapath, wrapping that function in a registered valid/ready pipeline. Inputs and outputs use valid/ready handshakes; back-pressure propagates without data loss.

## Interface
- WIDTH, 32, sample width (two's complement).
- ACC_WIDTH, 40, accumulator/result width; must be at least WIDTH+1.
- LEN_WIDTH, 8, window-length field width.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- win_len  input  LEN_WIDTH  samples per window; sampled on the first accepted sample of each window; 0 is treated as 1.
- in_valid  input  1  sample valid.
- in_ready  output  1  stage can accept a sample.
- in_data  input  WIDTH  signed sample.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_WIDTH  sum of |sample| over the window.
- out_ovf  output  1  accumulation exceeded 2^ACC_WIDTH-1 during this window.

## Operation
- Accept: a sample transfers when in_valid && in_ready.
- Stage 1 (abs): registers mag = in_data[WIDTH-1] ? -in_data : in_data, as unsigned WIDTH bits. The most negative value yields 2^(WIDTH-1) (0x8000_0000) with no overflow. It also registers s1_valid and s1_last.
- Window counter cnt: cleared to 0 at reset and after each window. It increments per accepted sample. s1_last = (cnt+1 == eff_len), where eff_len = max(win_len_latched, 1).
- Stage 2 (accumulate): acc <= (first ? 0 : acc) + mag, zero-extended to ACC_WIDTH+1. The carry-out sets the sticky ovf bit.
- FSM states:
  - ACCUM: stage 2 consumes s1. When s1_last is consumed, go to HOLD, load out_sum/out_ovf, and assert out_valid.
  - HOLD: out_valid=1 and outputs stable. On out_ready, go to ACCUM, clear acc/ovf, drop out_valid.
- in_ready = !(s1_valid && s1_last) && !(state==HOLD && !out_ready). No sample of the next window enters stage 1 while the previous result is pending, except in the cycle the result is being accepted.
- A win_len change mid-window has no effect until the next window's first sample.

## Timing
- Reset values: in_ready=0 during reset, 1 in the first cycle after release. out_valid=0, out_sum=0, out_ovf=0, cnt=0, acc=0, state=ACCUM, s1_valid=0.
- Latency: last sample accepted in cycle t -> out_valid high in cycle t+2.
- Throughput: one sample per cycle within a window. Minimum window turnaround is 1 bubble cycle when out_ready is held high.
- out_valid, once high, stays high with stable out_sum/out_ovf until out_ready is seen high at a clock edge.
- Simultaneous result acceptance and a new in_valid: the sample is accepted in the same cycle and becomes the first of the next window.
- Reset mid-window or mid-HOLD discards all partial state immediately (asynchronous). No result is emitted.

## Configuration
- ABS_SUM_SAT_EN defined: on carry-out, acc clamps to 2^ACC_WIDTH-1 and stays clamped for the rest of the window. out_ovf is still set.
- ABS_SUM_SAT_EN undefined: acc wraps modulo 2^ACC_WIDTH and out_ovf flags the wrap.

## Structure
- Shared package abs_sum_pkg holds:
  - default WIDTH/ACC_WIDTH/LEN_WIDTH constants;
  - the state enum (ACCUM, HOLD);
  - typedefs mag_t (unsigned WIDTH) and acc_t (unsigned ACC_WIDTH).
- One sub-module, abs_mag: purely combinational WIDTH-bit two's-complement to magnitude. It is instantiated in stage 1 and is reusable by neighbouring blocks.

## Test plan
- win_len=4, samples 5, -3, 0x8000_0000, -1 back-to-back, out_ready=1 -> out_sum=0x0_8000_0009 and out_ovf=0, two cycles after the last accept.
- win_len=0, sample -7 -> treated as a window of 1; out_sum=7, then next sample 2 -> out_sum=2.
- win_len=3 and out_ready=0 for 5 cycles after a result:
  - out_sum holds stable and in_ready=0 after the next window's first sample is blocked;
  - releasing out_ready yields the correct next window with no lost or duplicated samples.
- ACC_WIDTH=33 and win_len=4 with all samples 0x8000_0000:
  - with ABS_SUM_SAT_EN defined: out_sum=0x1_FFFF_FFFF and out_ovf=1;
  - with it undefined: out_sum=0x0_0000_0000 and out_ovf=1.
- rst_n pulsed low mid-window after 2 of 4 samples -> outputs return to reset values; the next 4 samples 1, 1, 1, 1 give out_sum=4.
- win_len changed from 4 to 2 mid-window -> current window still sums 4 samples; the following window sums 2.
